led_trail_pwm: RTL

- Downstream of the LED sweep FSM. Consumes its 8-bit one-hot LED pattern and its advance strobe.
- Drives the physical LED pins with per-LED PWM brightness.
- The lit LED is full-on. Previously lit LEDs fade out in steps, giving a decaying "comet tail" behind the sweep.

---
 rtl/led_trail_pwm.sv | 63 ++++++
 1 files changed

// File: rtl/led_trail_pwm.sv
// Comet-tail LED driver: the lit LED is full-on, previously lit LEDs fade by
// DECAY on every step, and each LED is pulse-width modulated from its brightness.
module led_trail_pwm #(
    parameter int PWM_BITS = 4,
    parameter int DECAY    = 4,
    parameter int N_LED    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_step,
    input  logic [N_LED-1:0] i_pattern,
    output logic [N_LED-1:0] o_led,
    output logic             o_frame
);

    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DEC = PWM_BITS'(DECAY);

    logic [PWM_BITS-1:0] br      [N_LED];
    logic [PWM_BITS-1:0] br_next [N_LED];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LED-1:0]    led_next;

    // A set pattern bit wins over a simultaneous step; decay saturates at zero.
    always_comb begin
        for (int k = 0; k < N_LED; k++) begin
            br_next[k] = br[k];
            if (i_pattern[k]) begin
                br_next[k] = MAX;
            end else if (i_step) begin
                br_next[k] = (br[k] > DEC) ? br[k] - DEC : '0;
            end
        end
    end

    // MAX is forced to 100% duty, since br > pwm_cnt alone would drop one cycle.
    always_comb begin
        led_next = '0;
        for (int k = 0; k < N_LED; k++) begin
            led_next[k] = i_enable & ((br[k] == MAX) | (br[k] > pwm_cnt));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < N_LED; k++) begin
                br[k] <= '0;
            end
            pwm_cnt <= '0;
            o_led   <= '0;
            o_frame <= 1'b0;
        end else begin
            for (int k = 0; k < N_LED; k++) begin
                br[k] <= br_next[k];
            end
            pwm_cnt <= i_enable ? pwm_cnt + 1'b1 : '0;
            o_led   <= led_next;
            o_frame <= i_enable & (pwm_cnt == MAX);
        end
    end

endmodule
